// File: rtl/simple_bus_pkg.sv
// ---------------------------------------------------------------------------
// simple_bus_pkg
//   Shared types and constants for simple_bus slaves and masters.
//   - bus_mode_e    : command encoding carried on the 2-bit mode field
//   - slave_state_e : handshake state of a memory-backed slave
//   - BURST_LEN     : beats returned by a burst read
//   - BUS_AW/BUS_DW : address and data widths of the bus
// ---------------------------------------------------------------------------
package simple_bus_pkg;

  localparam int BUS_AW    = 8;
  localparam int BUS_DW    = 8;
  localparam int BURST_LEN = 4;

  typedef enum logic [1:0] {
    MODE_RD    = 2'b00,
    MODE_WR    = 2'b01,
    MODE_BURST = 2'b10,
    MODE_RSVD  = 2'b11
  } bus_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_GRANTED = 2'b01,
    ST_WAIT    = 2'b10,
    ST_RESP    = 2'b11
  } slave_state_e;

endpackage

// File: rtl/simple_bus_slave_regfile.sv
// ---------------------------------------------------------------------------
// simple_bus_slave_regfile
//   DEPTH x BUS_DW storage array: synchronous write, combinational read.
//   Contents are never reset.
// Ports:
//   clk      in   write clock
//   we       in   write enable (ignored when addr is out of range)
//   addr     in   word address, shared by read and write
//   wdata    in   write data
//   rdata    out  mem[addr], or 0 when addr is out of range
//   in_range out  addr < DEPTH
// ---------------------------------------------------------------------------
module simple_bus_slave_regfile
  import simple_bus_pkg::*;
#(
  parameter int DEPTH = 256
) (
  input  logic              clk,
  input  logic              we,
  input  logic [BUS_AW-1:0] addr,
  input  logic [BUS_DW-1:0] wdata,
  output logic [BUS_DW-1:0] rdata,
  output logic              in_range
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [BUS_DW-1:0] mem_q [DEPTH];
  logic [IW-1:0]     idx;

  assign idx = addr[IW-1:0];

  // One extra bit so that DEPTH=256 compares correctly against an 8-bit address.
  assign in_range = ({1'b0, addr} < 9'(DEPTH));

  assign rdata = in_range ? mem_q[idx] : '0;

  always_ff @(posedge clk) begin
    if (we && in_range) begin
      mem_q[idx] <= wdata;
    end
  end

endmodule

// File: rtl/simple_bus_slave_mem.sv
// ---------------------------------------------------------------------------
// simple_bus_slave_mem
//   Memory-backed simple_bus slave. Grants a requesting master, accepts
//   read / write (and optionally burst-read) commands, inserts WAIT_CYCLES
//   wait states, then returns one rdy beat per data word. Reserved modes and
//   out-of-range addresses get an error beat (err=1, no data, no write).
//
//   Optional feature macro: SIMPLE_BUS_SLAVE_BURST_EN
//     defined   : mode 10 returns BURST_LEN beats of mem[(addr+k) mod 256],
//                 per-beat error for addresses >= DEPTH
//     undefined : mode 10 is answered like mode 11 (single error beat)
//
// Ports:
//   clk      in   bus clock
//   rst      in   asynchronous active-high reset
//   req      in   master requests ownership
//   start    in   command strobe (only honoured in GRANTED)
//   addr     in   command address
//   mode     in   00 read, 01 write, 10 burst read, 11 reserved
//   data_in  in   write data, sampled with start
//   gnt      out  slave has granted the master
//   rdy      out  response beat valid
//   err      out  error response, only ever high together with rdy
//   data_out out  read data for read beats, otherwise 0
//   data_oe  out  high on successful read beats only
// ---------------------------------------------------------------------------
module simple_bus_slave_mem
  import simple_bus_pkg::*;
#(
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              start,
  input  logic [BUS_AW-1:0] addr,
  input  logic [1:0]        mode,
  input  logic [BUS_DW-1:0] data_in,
  output logic              gnt,
  output logic              rdy,
  output logic              err,
  output logic [BUS_DW-1:0] data_out,
  output logic              data_oe
);

  localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES);

  slave_state_e      state_q, state_d;
  logic              gnt_q, gnt_d;
  logic              rdy_q, rdy_d;
  logic              err_q, err_d;
  logic [BUS_DW-1:0] data_out_q, data_out_d;
  logic              data_oe_q, data_oe_d;
  logic [3:0]        cnt_q, cnt_d;

  // Captured command; plain data, not reset.
  logic [BUS_AW-1:0] addr_q, addr_d;
  bus_mode_e         mode_q, mode_d;
  logic [BUS_DW-1:0] wdata_q, wdata_d;

`ifdef SIMPLE_BUS_SLAVE_BURST_EN
  logic [1:0]        beat_q, beat_d;
  logic [1:0]        beat_nxt;
`endif

  // Command seen by the response logic: straight from the bus in the start
  // cycle (needed when WAIT_CYCLES=0), otherwise the captured copy.
  logic [BUS_AW-1:0] cmd_addr;
  bus_mode_e         cmd_mode;
  logic [BUS_DW-1:0] cmd_wdata;

  logic [BUS_AW-1:0] rf_addr;
  logic [BUS_DW-1:0] rf_rdata;
  logic              rf_in_range;
  logic              rf_we;

  logic              enter_resp;
  logic              more_beats;
  logic              resp_bad;

  always_comb begin
    if (state_q == ST_GRANTED) begin
      cmd_addr  = addr;
      cmd_mode  = bus_mode_e'(mode);
      cmd_wdata = data_in;
    end else begin
      cmd_addr  = addr_q;
      cmd_mode  = mode_q;
      cmd_wdata = wdata_q;
    end
`ifdef SIMPLE_BUS_SLAVE_BURST_EN
    // Address of the beat being loaded at the next edge; wraps mod 256.
    beat_nxt = (state_q == ST_RESP) ? beat_q + 2'd1 : 2'd0;
    rf_addr  = cmd_addr + {{(BUS_AW-2){1'b0}}, beat_nxt};
`else
    rf_addr  = cmd_addr;
`endif
  end

  simple_bus_slave_regfile #(
    .DEPTH (DEPTH)
  ) u_regfile (
    .clk      (clk),
    .we       (rf_we),
    .addr     (rf_addr),
    .wdata    (cmd_wdata),
    .rdata    (rf_rdata),
    .in_range (rf_in_range)
  );

  // The write commits on the edge that enters RESP, never earlier, so a
  // reset during WAIT drops it.
  assign rf_we = enter_resp && (cmd_mode == MODE_WR) && rf_in_range;

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    rdy_d      = 1'b0;
    err_d      = 1'b0;
    data_out_d = '0;
    data_oe_d  = 1'b0;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    mode_d     = mode_q;
    wdata_d    = wdata_q;
`ifdef SIMPLE_BUS_SLAVE_BURST_EN
    beat_d     = beat_q;
`endif
    enter_resp = 1'b0;
    more_beats = 1'b0;
    resp_bad   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req) begin
          state_d = ST_GRANTED;
          gnt_d   = 1'b1;
        end
      end
      ST_GRANTED: begin
        if (!req) begin
          state_d = ST_IDLE;
          gnt_d   = 1'b0;
        end else if (start) begin
          addr_d  = addr;
          mode_d  = bus_mode_e'(mode);
          wdata_d = data_in;
          cnt_d   = CNT_LOAD;
          if (WAIT_CYCLES == 0) begin
            enter_resp = 1'b1;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          enter_resp = 1'b1;
        end
      end
      ST_RESP: begin
`ifdef SIMPLE_BUS_SLAVE_BURST_EN
        more_beats = (mode_q == MODE_BURST) && (beat_q != 2'(BURST_LEN - 1));
`endif
        if (more_beats) begin
          enter_resp = 1'b1;
        end else if (req) begin
          state_d = ST_GRANTED;
          gnt_d   = 1'b1;
        end else begin
          state_d = ST_IDLE;
          gnt_d   = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = 1'b0;
      end
    endcase

    // Load one response beat; gnt is held for the whole transaction.
    if (enter_resp) begin
      state_d = ST_RESP;
      gnt_d   = 1'b1;
      rdy_d   = 1'b1;
`ifdef SIMPLE_BUS_SLAVE_BURST_EN
      beat_d  = beat_nxt;
`endif
      resp_bad = (cmd_mode == MODE_RSVD) || !rf_in_range;
`ifndef SIMPLE_BUS_SLAVE_BURST_EN
      resp_bad = resp_bad || (cmd_mode == MODE_BURST);
`endif
      if (resp_bad) begin
        err_d = 1'b1;
      end else if (cmd_mode != MODE_WR) begin
        data_out_d = rf_rdata;
        data_oe_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      gnt_q      <= 1'b0;
      rdy_q      <= 1'b0;
      err_q      <= 1'b0;
      data_out_q <= '0;
      data_oe_q  <= 1'b0;
      cnt_q      <= 4'd0;
`ifdef SIMPLE_BUS_SLAVE_BURST_EN
      beat_q     <= 2'd0;
`endif
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      rdy_q      <= rdy_d;
      err_q      <= err_d;
      data_out_q <= data_out_d;
      data_oe_q  <= data_oe_d;
      cnt_q      <= cnt_d;
`ifdef SIMPLE_BUS_SLAVE_BURST_EN
      beat_q     <= beat_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    addr_q  <= addr_d;
    mode_q  <= mode_d;
    wdata_q <= wdata_d;
  end

  assign gnt      = gnt_q;
  assign rdy      = rdy_q;
  assign err      = err_q;
  assign data_out = data_out_q;
  assign data_oe  = data_oe_q;

endmodule

// File: doc/simple_bus_slave_mem.md
Name: simple_bus_slave_mem

Overview:
- Memory-backed responder that sits on the slave side of simple_bus, downstream of a bus master.
- Consumes the master's req/start/addr/mode/data and returns gnt, rdy, read data and an error flag.
- Supports single read, single write and an optional 4-beat burst read, with a programmable wait-state count.
- Used as the default target for bus masters in block-level and system benches.

Parameters:
- DEPTH, 256: number of 8-bit words stored; legal range 1..256; addresses >= DEPTH are out of range.
- WAIT_CYCLES, 2: wait states inserted between a sampled start and the first rdy; legal range 0..15.

Ports:
- clk  input  1  bus clock, same net as simple_bus clk
- rst  input  1  asynchronous active-high reset
- req  input  1  master requests ownership
- start  input  1  command strobe, sampled only in GRANTED
- addr  input  8  command address
- mode  input  2  00 read, 01 write, 10 burst read, 11 reserved
- data_in  input  8  write data, sampled with start
- gnt  output  1  slave has granted the master
- rdy  output  1  response beat valid, one cycle per beat
- err  output  1  qualifies rdy; high means error response
- data_out  output  8  read data, valid when rdy=1 and data_oe=1
- data_oe  output  1  slave drives bus data, high only on read beats

Behaviour:
- Reset (async, rst=1): state IDLE; gnt, rdy, err, data_oe = 0; data_out = 0; wait counter = 0. Memory contents are not reset.
- States: IDLE, GRANTED, WAIT, RESP.
- IDLE: req=1 at an edge -> GRANTED; gnt=1 from the next cycle.
- GRANTED (gnt=1):
  - req=0 -> IDLE, gnt=0.
  - start=1 -> capture addr, mode and data_in, load counter with WAIT_CYCLES, then go to WAIT (or straight to RESP if WAIT_CYCLES=0).
- WAIT: decrement the counter each cycle; when the counter reaches 1 at an edge -> RESP.
- Latency: rdy is high in the cycle that is WAIT_CYCLES+1 cycles after the cycle in which start was sampled.
- RESP:
  - Single read or write: rdy=1 for exactly 1 cycle.
  - Read: data_out=mem[addr], data_oe=1.
  - Write: mem[addr] updated on the edge entering RESP; data_oe=0, data_out=0.
- Error response:
  - Triggers: mode 11, or addr >= DEPTH.
  - Response: rdy=1 with err=1, data_out=0, data_oe=0, memory unchanged.
  - err is 0 whenever rdy=0.
- After the last rdy beat: req=1 -> GRANTED (back-to-back commands allowed, gnt stays high); req=0 -> IDLE.
- gnt stays high through WAIT and RESP even if req drops; the transaction always completes.
- start outside GRANTED is ignored. addr, mode and data_in are don't-care except in the start cycle.
- Reset mid-transaction: immediately abort; no pending write commits; outputs return to reset values.

Optional Feature:
- Macro: SIMPLE_BUS_SLAVE_BURST_EN.
- Defined: mode 10 produces 4 consecutive rdy cycles.
  - Beat k returns mem[(addr+k) mod 256].
  - Any beat whose address is >= DEPTH gets err=1 and data_out=0 for that beat only.
  - The wait states apply only before beat 0.
- Undefined: mode 10 is treated exactly like mode 11 (single error beat). No burst counter logic is synthesised.

Decomposition:
- Shared package simple_bus_pkg holds:
  - enum bus_mode_e {MODE_RD, MODE_WR, MODE_BURST, MODE_RSVD};
  - enum slave_state_e for the four states;
  - localparam BURST_LEN=4;
  - localparam BUS_AW=8 and BUS_DW=8.
- One sub-module: simple_bus_slave_regfile, a synchronous-write, combinational-read storage array of DEPTH x 8 with a range-check output.

Test Plan:
- Handshake (WAIT_CYCLES=2): reset, raise req -> gnt=1 the next cycle; drop req in GRANTED -> gnt=0 the next cycle.
- Write then read: write addr=0x10 data=0xA5, then read addr=0x10 -> first rdy 3 cycles after start; read returns data_out=0xA5, data_oe=1, err=0.
- Error cases (DEPTH=16):
  - write addr=0x20 -> rdy with err=1, and a later read of 0x00 is unaffected;
  - mode 11 -> single rdy with err=1.
- Burst with macro defined, WAIT_CYCLES=0, DEPTH=256:
  - preload 0xFE=0x11, 0xFF=0x22, 0x00=0x33, 0x01=0x44;
  - burst at 0xFE -> 4 consecutive rdy cycles carrying 11, 22, 33, 44 (wrap at 0xFF).
  - Without the macro, the same stimulus gives 1 rdy with err=1.
- Back-to-back and abort:
  - hold req, issue a read then a write -> gnt never drops between them;
  - assert rst during WAIT of a write to 0x05 (0x5A after 0x00) -> all outputs 0 immediately and a later read of 0x05 returns 0x00.
